keypad_entry: RTL
=================

KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter DEB_CYCLES, default 4, is the number of consecutive stable samples required to accept a key press or a key release.
REQ-002 clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 clr  in  1  reset, synchronous, active-high.
REQ-004 keys  in  10  raw digit keys; bit i is digit i, active-high.
REQ-005 key_start  in  1  raw start key, active-high.
REQ-006 key_cancel  in  1  raw cancel key, active-high.
REQ-007 timer_zero  in  1  high when the downstream timer chain reads 00:00.
REQ-008 data  out  16  BCD {min_tens, min_ones, sec_tens, sec_ones}, feeding the timer digit counters' data inputs.
REQ-009 loadn  out  1  active-low load strobe to the timer counters.
REQ-010 load_en  out  1  enable to the timer counters during the load cycle.
REQ-011 run  out  1  count enable to the timer chain.
REQ-012 err  out  1  one-cycle pulse on a rejected start.

Function
REQ-013 Each of the 12 raw inputs SHALL be debounced: a press is accepted after DEB_CYCLES consecutive high samples; a release is accepted after DEB_CYCLES consecutive low samples.
REQ-014 Each accepted press SHALL generate exactly one event pulse, however long the key is held.
REQ-015 A digit event SHALL be generated only if exactly one bit of keys is debounced-high; otherwise no digit event is generated.
REQ-016 When events coincide, priority SHALL be: cancel first, then start, then digit; lower-priority events in that cycle are discarded.
REQ-017 FSM states SHALL be IDLE, ENTRY, LOAD and RUN.
REQ-018 IDLE: a digit event moves to ENTRY with the digit loaded; start and cancel are ignored.
REQ-019 ENTRY, digit event: data SHALL shift left by one nibble, the new digit enters sec_ones and the old min_tens is discarded; the digit count saturates at 4.
REQ-020 ENTRY, cancel: data SHALL clear to 0 and the FSM returns to IDLE.
REQ-021 ENTRY, start with data==0 or sec_tens>5: err SHALL pulse for 1 cycle and the FSM stays in ENTRY with data unchanged.
REQ-022 ENTRY, valid start: the FSM moves to LOAD.
REQ-023 LOAD SHALL last exactly 1 cycle with loadn=0 and load_en=1; data is held stable; the next state is RUN.
REQ-024 RUN: run=1; digit and start events are ignored; data is held.
REQ-025 RUN: timer_zero=1 SHALL clear data to 0, drive run=0 and return to IDLE on the next edge.
REQ-026 RUN: cancel SHALL do the same as timer_zero; cancel and timer_zero together produce a single return to IDLE.
REQ-027 timer_zero SHALL be ignored in every state other than RUN.
REQ-028 Latency: with a raw key high from edge 1, the event is raised after edge DEB_CYCLES and data updates on edge DEB_CYCLES+1.
REQ-029 Outside LOAD, loadn=1 and load_en=0.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 When clr=1 at a rising edge: state=IDLE, data=0, loadn=1, load_en=0, run=0, err=0, digit count=0, all debounce counters and debounced levels=0.
REQ-032 clr SHALL take priority over all events, including in LOAD and RUN.
REQ-033 A key still held when clr is released SHALL register as a new press after DEB_CYCLES samples.

Structure
REQ-034 A shared timer package SHALL hold:
- the FSM state encoding;
- the BCD digit width (4);
- the seconds-tens limit (5);
- the default DEB_CYCLES.
REQ-035 Debouncing SHALL be a sub-module, key_debounce (parameter DEB_CYCLES; ports clk, clr, raw, level, press), instantiated 12 times.

Verification
REQ-036 Press 1, 3, 0 (each held 6 cycles, DEB_CYCLES=4), then start -> data=16'h0130; loadn=0 for exactly 1 cycle; then run=1.
REQ-037 Press 1, 2, 3, 4, 5 -> data=16'h2345; digit count stays 4.
REQ-038 Enter 0, 7, 0 (data=16'h0070), press start -> err pulses 1 cycle; state stays ENTRY; loadn stays 1.
REQ-039 Keys 3 and 4 held together for 10 cycles -> data unchanged. Key 5 bouncing 1-0-1 within 3 cycles -> no event.
REQ-040 In RUN, raise timer_zero -> run=0 on the next edge, data=0, state IDLE. Repeat with cancel and timer_zero in the same cycle -> single return to IDLE.
REQ-041 Assert clr during LOAD with key 9 held -> all outputs reset next edge. After clr drops, data becomes 16'h0009 on edge DEB_CYCLES+1.

Source files
------------

// File: rtl/keypad_entry_pkg.sv
// Shared constants for the keypad entry front end of the countdown timer:
// FSM encoding, BCD digit geometry and debounce defaults.
package keypad_entry_pkg;

  localparam int BCD_W          = 4;
  localparam int NUM_DIGITS     = 4;
  localparam int NUM_DIGIT_KEYS = 10;
  localparam int DEB_CYCLES_DEF = 4;

  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ENTRY = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

endpackage

// File: rtl/keypad_entry_debounce.sv
// Single-input debouncer: accepts a level change after DEB_CYCLES consecutive
// samples that differ from the current debounced level; pulses press on a rise.
module key_debounce
  import keypad_entry_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CW-1:0] cnt;

  // cnt holds how many consecutive samples have disagreed with level so far
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else if (raw != level) begin
      if (cnt == CW'(DEB_CYCLES - 1)) begin
        cnt   <= '0;
        level <= raw;
        press <= raw;
      end else begin
        cnt   <= cnt + 1'b1;
        press <= 1'b0;
      end
    end else begin
      cnt   <= '0;
      press <= 1'b0;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry controller: debounces digit/start/cancel keys, assembles an
// MM:SS BCD value and loads/starts the downstream timer counter chain.
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [9:0]  keys,
  input  logic        key_start,
  input  logic        key_cancel,
  input  logic        timer_zero,
  output logic [15:0] data,
  output logic        loadn,
  output logic        load_en,
  output logic        run,
  output logic        err
);

  logic [11:0] raw, level, press;
  assign raw = {key_cancel, key_start, keys};

  for (genvar i = 0; i < 12; i++) begin : g_deb
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .clr   (clr),
      .raw   (raw[i]),
      .level (level[i]),
      .press (press[i])
    );
  end

  logic             ev_cancel, ev_start, ev_digit;
  logic [BCD_W-1:0] digit;

  assign ev_cancel = press[11];
  assign ev_start  = press[10];
  // A press only counts as a digit when it is the sole digit key held down
  assign ev_digit  = (|press[NUM_DIGIT_KEYS-1:0]) && $onehot(level[NUM_DIGIT_KEYS-1:0]);

  always_comb begin
    digit = '0;
    for (int i = 0; i < NUM_DIGIT_KEYS; i++) begin
      if (level[i]) digit = BCD_W'(i);
    end
  end

  logic [1:0]  state, state_nx;
  logic [2:0]  digit_cnt, cnt_nx;
  logic [15:0] data_nx;
  logic        err_nx;
  logic        start_bad;

  assign start_bad = (data == 16'h0000) || (data[2*BCD_W-1:BCD_W] > SEC_TENS_MAX);

  always_comb begin
    state_nx = state;
    data_nx  = data;
    cnt_nx   = digit_cnt;
    err_nx   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ev_digit) begin
          state_nx = ST_ENTRY;
          data_nx  = {12'h000, digit};
          cnt_nx   = 3'd1;
        end
      end
      ST_ENTRY: begin
        if (ev_cancel) begin
          state_nx = ST_IDLE;
          data_nx  = '0;
          cnt_nx   = '0;
        end else if (ev_start) begin
          if (start_bad) err_nx = 1'b1;
          else           state_nx = ST_LOAD;
        end else if (ev_digit) begin
          data_nx = {data[15-BCD_W:0], digit};
          if (digit_cnt != 3'(NUM_DIGITS)) cnt_nx = digit_cnt + 3'd1;
        end
      end
      ST_LOAD: state_nx = ST_RUN;
      default: begin
        if (ev_cancel || timer_zero) begin
          state_nx = ST_IDLE;
          data_nx  = '0;
          cnt_nx   = '0;
        end
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_IDLE;
      data      <= '0;
      digit_cnt <= '0;
      loadn     <= 1'b1;
      load_en   <= 1'b0;
      run       <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      data      <= data_nx;
      digit_cnt <= cnt_nx;
      loadn     <= (state_nx != ST_LOAD);
      load_en   <= (state_nx == ST_LOAD);
      run       <= (state_nx == ST_RUN);
      err       <= err_nx;
    end
  end

endmodule
